// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
// 32-entry general-purpose register file for the MIPS core.
//   - Two combinational read ports (rs, rt) serve the decode stage.
//   - One write port fed by the write-back stage (data, destination, enable).
//   - A sequential dump port (valid/ready) streams every register out, in
//     index order, for the debug unit after a halt.
// Register 0 is hardwired to zero: writes to it are dropped, reads give 0.
//
// Optional feature macro: REGFILE_WRITE_FIRST_EN
//   defined   -> write-first bypass: a write to the address being read shows
//                up on that read port (and on the dump data) in the same cycle.
//   undefined -> reads return the pre-write array value in the write cycle.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_rs_addr / o_rs_data          read port A
//   i_rt_addr / o_rt_data          read port B
//   i_write_data, i_reg2write,
//   i_regWrite                     write-back stage write port
//   i_dump_start                   start a dump (sampled only while idle)
//   i_dump_ready                   consumer accepts the current dump word
//   o_dump_valid, o_dump_addr,
//   o_dump_data                    current dump word
//   o_dump_busy                    dump FSM not idle
//   o_dump_done                    one-cycle pulse after the last word
// ---------------------------------------------------------------------------
module register_file #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  output logic [NB_DATA-1:0] o_rs_data,
  output logic [NB_DATA-1:0] o_rt_data,
  input  logic [NB_DATA-1:0] i_write_data,
  input  logic [NB_ADDR-1:0] i_reg2write,
  input  logic               i_regWrite,
  input  logic               i_dump_start,
  input  logic               i_dump_ready,
  output logic               o_dump_valid,
  output logic [NB_ADDR-1:0] o_dump_addr,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_busy,
  output logic               o_dump_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [NB_ADDR-1:0] ADDR_ZERO = {NB_ADDR{1'b0}};
  localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(N_REGS - 1);
  localparam logic [NB_DATA-1:0] DATA_ZERO = {NB_DATA{1'b0}};

  logic [NB_DATA-1:0] mem_q [N_REGS];
  logic [NB_DATA-1:0] mem_d [N_REGS];

  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               write_en_s;
  logic [NB_DATA-1:0] rs_data_s, rt_data_s, dump_data_s;

  assign write_en_s = i_regWrite && (i_reg2write != ADDR_ZERO);

  // Next array contents: only the addressed nonzero entry changes.
  always_comb begin
    mem_d = mem_q;
    if (write_en_s) begin
      mem_d[i_reg2write] = i_write_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Read ports and dump data; address 0 is forced to zero explicitly.
  always_comb begin
    rs_data_s   = DATA_ZERO;
    rt_data_s   = DATA_ZERO;
    dump_data_s = DATA_ZERO;
`ifdef REGFILE_WRITE_FIRST_EN
    if (write_en_s && (i_reg2write == i_rs_addr)) begin
      rs_data_s = i_write_data;
    end else if (i_rs_addr != ADDR_ZERO) begin
      rs_data_s = mem_q[i_rs_addr];
    end else begin
      rs_data_s = DATA_ZERO;
    end
    if (write_en_s && (i_reg2write == i_rt_addr)) begin
      rt_data_s = i_write_data;
    end else if (i_rt_addr != ADDR_ZERO) begin
      rt_data_s = mem_q[i_rt_addr];
    end else begin
      rt_data_s = DATA_ZERO;
    end
    if (write_en_s && (i_reg2write == idx_q)) begin
      dump_data_s = i_write_data;
    end else if (idx_q != ADDR_ZERO) begin
      dump_data_s = mem_q[idx_q];
    end else begin
      dump_data_s = DATA_ZERO;
    end
`else
    if (i_rs_addr != ADDR_ZERO) begin
      rs_data_s = mem_q[i_rs_addr];
    end else begin
      rs_data_s = DATA_ZERO;
    end
    if (i_rt_addr != ADDR_ZERO) begin
      rt_data_s = mem_q[i_rt_addr];
    end else begin
      rt_data_s = DATA_ZERO;
    end
    if (idx_q != ADDR_ZERO) begin
      dump_data_s = mem_q[idx_q];
    end else begin
      dump_data_s = DATA_ZERO;
    end
`endif
  end

  // Dump FSM next state; output flags are computed here so they come out of flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          state_d = ST_SEND;
          idx_d   = ADDR_ZERO;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (valid_q && i_dump_ready) begin
          if (idx_q == ADDR_LAST) begin
            state_d = ST_DONE;
            idx_d   = ADDR_ZERO;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + {{(NB_ADDR-1){1'b0}}, 1'b1};
          end
        end else begin
          // Consumer stalled: hold the current index.
          idx_d = idx_q;
        end
      end
      ST_DONE: begin
        // Start is ignored here; a held start is picked up from IDLE next cycle.
        state_d = ST_IDLE;
        idx_d   = ADDR_ZERO;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = ADDR_ZERO;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers: register array and dump FSM, cleared by async reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
      state_q <= ST_IDLE;
      idx_q   <= ADDR_ZERO;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_rs_data    = rs_data_s;
  assign o_rt_data    = rt_data_s;
  assign o_dump_valid = valid_q;
  assign o_dump_addr  = idx_q;
  assign o_dump_data  = dump_data_s;
  assign o_dump_busy  = busy_q;
  assign o_dump_done  = done_q;

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
// Directed stimulus with hand-computed expectations pushed into queues; a
// negedge monitor pops and compares whenever a read check is flagged or a
// dump word is transferred (valid && ready).
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] write_data;
  logic [4:0]  reg2write;
  logic        reg_write;
  logic        dump_start, dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy, dump_done;

  register_file dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rs_addr    (rs_addr),
    .i_rt_addr    (rt_addr),
    .o_rs_data    (rs_data),
    .o_rt_data    (rt_data),
    .i_write_data (write_data),
    .i_reg2write  (reg2write),
    .i_regWrite   (reg_write),
    .i_dump_start (dump_start),
    .i_dump_ready (dump_ready),
    .o_dump_valid (dump_valid),
    .o_dump_addr  (dump_addr),
    .o_dump_data  (dump_data),
    .o_dump_busy  (dump_busy),
    .o_dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] rs_exp_q [$];
  logic [31:0] rt_exp_q [$];
  logic [4:0]  da_exp_q [$];
  logic [31:0] dd_exp_q [$];
  logic        rd_chk;
  int          words_rx = 0;
  int          done_cnt = 0;
  int          valid_cycles = 0;

`ifdef REGFILE_WRITE_FIRST_EN
  localparam logic [31:0] HAZARD_EXP = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] HAZARD_EXP = 32'h0000_0001;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare read ports when flagged, dump words on each transfer.
  always @(negedge clk) begin
    if (rd_chk) begin
      if (rs_exp_q.size() == 0 || rt_exp_q.size() == 0) begin
        chk("read_queue_empty", 32'd1, 32'd0);
      end else begin
        chk("rs_data", rs_data, rs_exp_q.pop_front());
        chk("rt_data", rt_data, rt_exp_q.pop_front());
      end
    end
    if (dump_valid) valid_cycles++;
    if (dump_valid && dump_ready) begin
      words_rx++;
      if (da_exp_q.size() == 0) begin
        chk("dump_unexpected_word", {27'd0, dump_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("dump_addr", {27'd0, dump_addr}, {27'd0, da_exp_q.pop_front()});
        chk("dump_data", dump_data, dd_exp_q.pop_front());
      end
    end
    if (dump_done) done_cnt++;
  end

  // One stimulus cycle; inputs change 1 time unit after the rising edge.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic c,
                       input logic [31:0] er, input logic [31:0] et);
    @(posedge clk); #1;
    reg_write  = we;
    reg2write  = wa;
    write_data = wd;
    rs_addr    = ra;
    rt_addr    = rb;
    rd_chk     = c;
    if (c) begin
      rs_exp_q.push_back(er);
      rt_exp_q.push_back(et);
    end
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'(i) * 32'h11, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    end
    idle();
  endtask

  task automatic read_sweep_zero();
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b1, 32'd0, 32'd0);
    end
    idle();
  endtask

  task automatic start_dump(input logic rdy);
    @(posedge clk); #1;
    dump_ready = rdy;
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (dump_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("dump_done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("busy_after_done", {31'd0, dump_busy}, 32'd0);
    chk("done_one_cycle", {31'd0, dump_done}, 32'd0);
  endtask

  initial begin
    int rx0, dn0, vc0, pi;
    bit wrote, seen;

    rst_n = 1'b1; rd_chk = 1'b0;
    rs_addr = 5'd0; rt_addr = 5'd0; write_data = 32'd0; reg2write = 5'd0;
    reg_write = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_dump_busy",  {31'd0, dump_busy},  32'd0);
    chk("rst_dump_done",  {31'd0, dump_done},  32'd0);
    chk("rst_dump_addr",  {27'd0, dump_addr},  32'd0);
    rst_n = 1'b1;

    // Reset contents: all zero.
    read_sweep_zero();

    // Basic write/read and r0 hardwiring.
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 32'hDEAD_BEEF, 32'd0);
    drive(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 1'b1, 32'd0, 32'hDEAD_BEEF);
    // Write to r0 with a same-cycle read of r0 must still read 0.
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0);

    // Same-cycle hazard on r7.
    drive(1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 1'b1, HAZARD_EXP, HAZARD_EXP);
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    idle();

    // Full dump with ready held high.
    preload();
    for (int i = 0; i < 32; i++) begin
      da_exp_q.push_back(5'(i));
      dd_exp_q.push_back(32'(i) * 32'h11);
    end
    rx0 = words_rx; dn0 = done_cnt; vc0 = valid_cycles;
    start_dump(1'b1);
    wait_done(100);
    chk("full_words",        32'(words_rx - rx0),     32'd32);
    chk("full_valid_cycles", 32'(valid_cycles - vc0), 32'd32);
    chk("full_done_pulses",  32'(done_cnt - dn0),     32'd1);
    chk("full_queue_left",   32'(da_exp_q.size()),    32'd0);

    // Backpressure with a write to the held index 3.
    for (int i = 0; i < 32; i++) begin
      da_exp_q.push_back(5'(i));
      dd_exp_q.push_back((i == 3) ? 32'h0000_CAFE : 32'(i) * 32'h11);
    end
    rx0 = words_rx; dn0 = done_cnt;
    start_dump(1'b0);
    wrote = 1'b0; pi = 0; seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k != 0) begin
        @(posedge clk); #1;
      end
      reg_write = 1'b0;
      if (dump_done) begin
        seen = 1'b1;
        break;
      end
      if (dump_valid && dump_addr == 5'd3 && !wrote) begin
        dump_ready = 1'b0;
        reg_write  = 1'b1;
        reg2write  = 5'd3;
        write_data = 32'h0000_CAFE;
        wrote      = 1'b1;
      end else begin
        dump_ready = (pi % 3 == 0);
        pi++;
      end
    end
    chk("bp_done_seen", {31'd0, seen}, 32'd1);
    dump_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_busy_after_done", {31'd0, dump_busy}, 32'd0);
    chk("bp_words",       32'(words_rx - rx0),  32'd32);
    chk("bp_done_pulses", 32'(done_cnt - dn0),  32'd1);
    chk("bp_queue_left",  32'(da_exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a dump at addr 10.
    for (int i = 0; i < 10; i++) begin
      da_exp_q.push_back(5'(i));
      dd_exp_q.push_back((i == 3) ? 32'h0000_CAFE : 32'(i) * 32'h11);
    end
    dn0 = done_cnt;
    start_dump(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (dump_valid && dump_addr == 5'd10) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("mid_addr10_seen", {31'd0, seen}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, dump_busy},  32'd0);
    chk("mid_rst_done",  {31'd0, dump_done},  32'd0);
    chk("mid_rst_addr",  {27'd0, dump_addr},  32'd0);
    chk("mid_queue_left", 32'(da_exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_no_done", 32'(done_cnt - dn0), 32'd0);
    read_sweep_zero();

    // Fresh dump after reset: all zeros, starting at addr 0.
    for (int i = 0; i < 32; i++) begin
      da_exp_q.push_back(5'(i));
      dd_exp_q.push_back(32'd0);
    end
    rx0 = words_rx; dn0 = done_cnt;
    start_dump(1'b1);
    wait_done(100);
    chk("post_rst_words",       32'(words_rx - rx0),  32'd32);
    chk("post_rst_done_pulses", 32'(done_cnt - dn0),  32'd1);
    chk("post_rst_queue_left",  32'(da_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
